// File: rtl/serial_addsub_pkg.sv
// Shared types and constants for the bit-serial adder/subtractor.
package serial_addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/serial_addsub_full_adder.sv
// Single-bit combinational full adder used as the serial datapath cell.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial WIDTH-bit adder/subtractor: one full-adder cell, LSB first, start/busy/done handshake.
module serial_addsub
  import serial_addsub_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow
);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_sh_q, a_sh_d;
  logic [WIDTH-1:0]   b_sh_q, b_sh_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               mode_q, mode_d;
  logic               carry_reg_q, carry_reg_d;
  logic               carry_q, carry_d;
  logic               overflow_q, overflow_d;

  logic               fa_sum;
  logic               fa_cout;
  logic               last_bit;

  full_adder u_fa (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .cin  (carry_reg_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

  always_comb begin
    state_d     = state_q;
    a_sh_d      = a_sh_q;
    b_sh_d      = b_sh_q;
    result_d    = result_q;
    cnt_d       = cnt_q;
    mode_d      = mode_q;
    carry_reg_d = carry_reg_q;
    carry_d     = carry_q;
    overflow_d  = overflow_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          // Subtraction is a + ~b + 1: invert B here and seed the carry with 1.
          a_sh_d      = a;
          b_sh_d      = b ^ {WIDTH{mode}};
          mode_d      = mode;
          carry_reg_d = mode;
          cnt_d       = '0;
          state_d     = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_sh_d      = a_sh_q >> 1;
        b_sh_d      = b_sh_q >> 1;
        result_d    = {fa_sum, result_q[WIDTH-1:1]};
        carry_reg_d = fa_cout;
        cnt_d       = cnt_q + CNT_W'(1);
        if (last_bit) begin
          // On the MSB the shift-register LSBs hold a[MSB] and the latched b'[MSB].
          carry_d    = (mode_q == MODE_SUB) ? ~fa_cout : fa_cout;
          overflow_d = (a_sh_q[0] == b_sh_q[0]) && (fa_sum != a_sh_q[0]);
          state_d    = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      result_q    <= '0;
      cnt_q       <= '0;
      mode_q      <= 1'b0;
      carry_reg_q <= 1'b0;
      carry_q     <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_sh_q      <= a_sh_d;
      b_sh_q      <= b_sh_d;
      result_q    <= result_d;
      cnt_q       <= cnt_d;
      mode_q      <= mode_d;
      carry_reg_q <= carry_reg_d;
      carry_q     <= carry_d;
      overflow_q  <= overflow_d;
    end
  end

  assign busy     = (state_q == RUN);
  assign done     = (state_q == DONE);
  assign result   = result_q;
  assign carry    = carry_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Directed bench for serial_addsub at WIDTH=8 and WIDTH=16.
module tb_serial_addsub;

  logic        clk;
  logic        rst_n;

  logic        start8, mode8, busy8, done8, carry8, ovf8;
  logic [7:0]  a8, b8, res8;

  logic        start16, mode16, busy16, done16, carry16, ovf16;
  logic [15:0] a16, b16, res16;

  int tests_run;
  int tests_failed;

  serial_addsub #(.WIDTH(8)) dut8 (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start8),
    .mode     (mode8),
    .a        (a8),
    .b        (b8),
    .busy     (busy8),
    .done     (done8),
    .result   (res8),
    .carry    (carry8),
    .overflow (ovf8)
  );

  serial_addsub #(.WIDTH(16)) dut16 (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start16),
    .mode     (mode16),
    .a        (a16),
    .b        (b16),
    .busy     (busy16),
    .done     (done16),
    .result   (res16),
    .carry    (carry16),
    .overflow (ovf16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present one 8-bit operation, then count clocks from the accepting edge to done.
  task automatic op8(input logic m, input logic [7:0] x, input logic [7:0] y, output int lat);
    @(negedge clk);
    start8 = 1'b1; mode8 = m; a8 = x; b8 = y;
    @(posedge clk); #1;
    start8 = 1'b0;
    lat = 0;
    while (!done8 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic op16(input logic m, input logic [15:0] x, input logic [15:0] y, output int lat);
    @(negedge clk);
    start16 = 1'b1; mode16 = m; a16 = x; b16 = y;
    @(posedge clk); #1;
    start16 = 1'b0;
    lat = 0;
    while (!done16 && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic vec8(input string tag, input logic m, input logic [7:0] x, input logic [7:0] y,
                      input logic [7:0] er, input logic ec, input logic eo);
    int lat;
    op8(m, x, y, lat);
    check({tag, "_lat"}, lat, 8);
    check({tag, "_res"}, res8, er);
    check({tag, "_carry"}, carry8, ec);
    check({tag, "_ovf"}, ovf8, eo);
    @(posedge clk); #1;
    check({tag, "_done_1cyc"}, done8, 1'b0);
  endtask

  initial begin
    int lat;
    int pulses;
    logic [16:0] full;
    logic [15:0] ra, rb, er;
    logic        ec, eo, m;

    tests_run = 0; tests_failed = 0;
    rst_n = 1'b0;
    start8 = 0; mode8 = 0; a8 = 0; b8 = 0;
    start16 = 0; mode16 = 0; a16 = 0; b16 = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy8, 1'b0);
    check("rst_done", done8, 1'b0);
    check("rst_res", res8, 8'h00);
    check("rst_flags", {carry8, ovf8}, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;

    vec8("add_200_100", 1'b0, 8'd200, 8'd100, 8'd44,  1'b1, 1'b0);
    vec8("add_100_100", 1'b0, 8'd100, 8'd100, 8'hC8,  1'b0, 1'b1);
    vec8("sub_5_7",     1'b1, 8'd5,   8'd7,   8'hFE,  1'b1, 1'b0);
    vec8("sub_80_1",    1'b1, 8'h80,  8'h01,  8'h7F,  1'b0, 1'b1);
    check("hold_res", res8, 8'h7F);

    // start re-pulsed mid-run with other operands must be ignored
    @(negedge clk);
    start8 = 1'b1; mode8 = 1'b0; a8 = 8'd10; b8 = 8'd20;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    start8 = 1'b1; mode8 = 1'b1; a8 = 8'd99; b8 = 8'd1;
    @(negedge clk);
    start8 = 1'b0;
    lat = 4;
    while (!done8 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("midrun_lat", lat, 8);
    check("midrun_res", res8, 8'd30);
    @(posedge clk); #1;

    // start held through DONE: second op begins immediately, one done per op
    @(negedge clk);
    start8 = 1'b1; mode8 = 1'b0; a8 = 8'd3; b8 = 8'd4;
    @(posedge clk); #1;
    lat = 0; pulses = 0;
    while (!done8 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("b2b_lat1", lat, 8);
    check("b2b_res1", res8, 8'd7);
    pulses += done8;
    a8 = 8'd50; b8 = 8'd60; mode8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    check("b2b_busy", busy8, 1'b1);
    check("b2b_done_drop", done8, 1'b0);
    lat = 0;
    while (!done8 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("b2b_lat2", lat, 8);
    check("b2b_res2", res8, 8'hF6);
    check("b2b_borrow2", carry8, 1'b1);
    pulses += done8;
    repeat (4) begin
      @(posedge clk); #1;
      pulses += done8;
    end
    check("b2b_pulses", pulses, 2);

    // asynchronous reset in the middle of a run
    @(negedge clk);
    start8 = 1'b1; mode8 = 1'b0; a8 = 8'hFF; b8 = 8'hFF;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_busy", busy8, 1'b0);
    check("arst_res", res8, 8'h00);
    check("arst_flags", {carry8, ovf8, done8}, 3'b000);
    pulses = 0;
    repeat (10) begin
      @(posedge clk); #1;
      pulses += done8;
    end
    check("arst_nodone", pulses, 0);
    @(negedge clk);
    rst_n = 1'b1;
    vec8("post_rst_1p1", 1'b0, 8'd1, 8'd1, 8'd2, 1'b0, 1'b0);

    // 16-bit sweep against an independent arithmetic model
    for (int i = 0; i < 20; i++) begin
      m  = i[0];
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (i == 0) begin ra = 16'h8000; rb = 16'h0001; end
      if (i == 1) begin ra = 16'h7FFF; rb = 16'h0001; end
      if (m == 1'b0) begin
        full = {1'b0, ra} + {1'b0, rb};
        er = full[15:0];
        ec = full[16];
        eo = (ra[15] == rb[15]) && (er[15] != ra[15]);
      end else begin
        er = ra - rb;
        ec = (ra < rb);
        eo = (ra[15] != rb[15]) && (er[15] != ra[15]);
      end
      op16(m, ra, rb, lat);
      check($sformatf("w16_%0d_lat", i), lat, 16);
      check($sformatf("w16_%0d_res", i), res16, er);
      check($sformatf("w16_%0d_flags", i), {carry16, ovf16}, {ec, eo});
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/serial_addsub.md
Name: serial_addsub

Overview:
Parametrised bit-serial adder/subtractor that computes an N-bit sum or difference using one full-adder cell, one bit per clock, LSB first. It is the sequential successor to the combinational half adder: it adds carry-in, subtract mode, width generalisation, a carry/borrow flag, a signed-overflow flag and a start/busy/done handshake. It sits as a small-area arithmetic unit behind a simple controller.

Parameters:
WIDTH, 8, operand and result width in bits (WIDTH >= 2)
CNT_W, $clog2(WIDTH+1), bit-counter width (derived; not overridden)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE or DONE
mode  input  1  0 = add (a+b), 1 = subtract (a-b); sampled with start
a  input  WIDTH  operand A; sampled with start
b  input  WIDTH  operand B; sampled with start
busy  output  1  high while bits are being processed
done  output  1  one-cycle pulse; result and flags are valid
result  output  WIDTH  sum or difference (mod 2^WIDTH)
carry  output  1  add: carry-out; subtract: borrow (= ~carry-out)
overflow  output  1  two's-complement signed overflow

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy=0, done=0, result=0, carry=0, overflow=0; internal shift registers, carry register and counter cleared. Reset mid-operation aborts it with no done pulse.
- FSM states: IDLE, RUN, DONE.
- IDLE: start=1 at edge k -> latch a, b^{WIDTH{mode}}, mode; carry_reg=mode; cnt=0; state=RUN; busy=1.
- RUN: each edge processes bit cnt: sum=a0^b0^carry_reg, carry_reg<=majority; shift the sum into result MSB end; shift A and B right; cnt++. The edge processing bit WIDTH-1 (edge k+WIDTH) -> state=DONE.
- Entering DONE: busy=0, done=1 for exactly one cycle. carry=final carry (add) or ~final carry (sub). overflow=(a[MSB]==b'[MSB]) && (result[MSB]!=a[MSB]), using the latched, possibly inverted B.
- Latency: done is high in the cycle after edge k+WIDTH, i.e. WIDTH clocks after the accepting edge.
- DONE: start=1 is accepted for a back-to-back operation with the same actions as in IDLE, and done drops. Otherwise -> IDLE.
- result, carry and overflow hold their values from DONE until the next accepted start. The shift register may change visible result bits during RUN; consumers must sample only on done.
- start while in RUN is ignored. Operands and mode are not re-sampled.
- a, b and mode changing after acceptance have no effect.
- Arithmetic is modulo 2^WIDTH. There is no saturation.

Decomposition:
- Package serial_addsub_pkg holds the state enum (IDLE, RUN, DONE) and the constants MODE_ADD=1'b0 and MODE_SUB=1'b1.
- Sub-module full_adder (a, b, cin -> sum, cout) is purely combinational and instantiated once. The top holds the FSM, counter, operand shift registers and carry register.

Test Plan:
- WIDTH=8, add a=200, b=100 -> done exactly 8 clocks after start edge; result=44, carry=1, overflow=0.
- Add a=100, b=100 -> result=200 (0xC8), carry=0, overflow=1.
- Sub a=5, b=7 -> result=0xFE, carry(borrow)=1, overflow=0. Sub a=0x80, b=1 -> result=0x7F, borrow=0, overflow=1.
- start pulsed again mid-RUN with different operands -> ignored; the original result is still produced on schedule. start held high through DONE -> second operation begins immediately, with exactly one done pulse per operation.
- rst_n dropped at bit 4 of a run -> outputs 0 immediately (asynchronous), no done. After release, a new add 1+1 -> result=2.
- WIDTH=16 sweep of random operands with both modes against a reference model -> result, carry and overflow match, and latency = 16.
